// File: rtl/cv32e41s_ctrl_scoreboard_pkg.sv
// Shared types and helpers for the control scoreboard: the per-stage entry
// record and the width of a forwarding select for a given pipeline depth.
package cv32e41s_ctrl_scoreboard_pkg;

    // Entries store addresses zero-extended to this width; ADDR_WIDTH must not exceed it.
    localparam int SB_MAX_ADDR_W = 8;
    localparam int SB_SEL_RF     = 0;

    typedef struct packed {
        logic                     valid;
        logic                     we;
        logic [SB_MAX_ADDR_W-1:0] waddr;
    } sb_entry_t;

    function automatic int sb_sel_w(input int pipe_depth);
        return $clog2(pipe_depth + 1);
    endfunction

endpackage

// File: rtl/cv32e41s_ctrl_scoreboard_if.sv
// Stage handshake, read-port and forwarding signals between the pipeline
// controller (master) and the scoreboard (slave).
interface cv32e41s_ctrl_scoreboard_if
    import cv32e41s_ctrl_scoreboard_pkg::*;
#(
    parameter int REGFILE_NUM_READ_PORTS = 2,
    parameter int PIPE_DEPTH             = 2,
    parameter int ADDR_WIDTH             = 5
);
    localparam int SB_SEL_W = sb_sel_w(PIPE_DEPTH);

    logic                                         issue_valid_i;
    logic                                         issue_we_i;
    logic [ADDR_WIDTH-1:0]                        issue_waddr_i;
    logic [PIPE_DEPTH-1:0]                        adv_i;
    logic [PIPE_DEPTH-1:0]                        kill_i;
    logic [PIPE_DEPTH-1:0]                        result_rdy_i;
    logic [REGFILE_NUM_READ_PORTS-1:0]            rf_re_i;
    logic [REGFILE_NUM_READ_PORTS*ADDR_WIDTH-1:0] rf_raddr_i;
    logic [REGFILE_NUM_READ_PORTS*SB_SEL_W-1:0]   fwd_sel_o;
    logic                                         stall_o;

    modport master (
        output issue_valid_i, issue_we_i, issue_waddr_i, adv_i, kill_i,
               result_rdy_i, rf_re_i, rf_raddr_i,
        input  fwd_sel_o, stall_o
    );

    modport slave (
        input  issue_valid_i, issue_we_i, issue_waddr_i, adv_i, kill_i,
               result_rdy_i, rf_re_i, rf_raddr_i,
        output fwd_sel_o, stall_o
    );

endinterface

// File: rtl/cv32e41s_ctrl_scoreboard_sb_match.sv
// Priority lookup for one register-file read port: the youngest in-flight
// writer of the read address selects a forwarding stage or raises a hazard.
module cv32e41s_sb_match
    import cv32e41s_ctrl_scoreboard_pkg::*;
#(
    parameter int PIPE_DEPTH = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int SEL_W      = 2
) (
    input  sb_entry_t [PIPE_DEPTH-1:0] entries,
    input  logic      [PIPE_DEPTH-1:0] result_rdy,
    input  logic                       re,
    input  logic      [ADDR_WIDTH-1:0] raddr,
    output logic      [SEL_W-1:0]      sel,
    output logic                       hazard
);

    logic found;

    // x0 is never forwarded; the lowest-numbered stage holds the youngest writer.
    always_comb begin
        sel    = SEL_W'(SB_SEL_RF);
        hazard = 1'b0;
        found  = 1'b0;
        if (re && (raddr != '0)) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                if (!found && entries[k].valid && entries[k].we &&
                    (entries[k].waddr == SB_MAX_ADDR_W'(raddr))) begin
                    found = 1'b1;
                    if (result_rdy[k]) begin
                        sel = SEL_W'(k + 1);
                    end else begin
                        hazard = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/cv32e41s_ctrl_scoreboard.sv
// Register-write scoreboard over PIPE_DEPTH post-ID stages with per-port forwarding
// selects and an ID stall; the stall counter is built only with CV32E41S_SB_STALL_CNT_EN.
module cv32e41s_ctrl_scoreboard
    import cv32e41s_ctrl_scoreboard_pkg::*;
#(
    parameter int REGFILE_NUM_READ_PORTS = 2,
    parameter int PIPE_DEPTH             = 2,
    parameter int ADDR_WIDTH             = 5,
    parameter int CNT_WIDTH              = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    cv32e41s_ctrl_scoreboard_if.slave    sb,
    input  logic                         stall_cnt_clr_i,
    output logic [CNT_WIDTH-1:0]         stall_cnt_o
);

    localparam int SB_SEL_W = sb_sel_w(PIPE_DEPTH);

    sb_entry_t [PIPE_DEPTH-1:0]             entry_q;
    sb_entry_t [PIPE_DEPTH-1:0]             entry_d;
    logic      [REGFILE_NUM_READ_PORTS-1:0] hazard;
    logic      [PIPE_DEPTH-1:0]             incoming;
    logic      [PIPE_DEPTH-1:0]             held;
    logic                                   stall;

    // Kill beats any transfer into a stage; a transfer beats the stage draining.
    always_comb begin
        entry_d = entry_q;
        if (sb.kill_i[0]) begin
            entry_d[0] = '0;
        end else if (sb.issue_valid_i) begin
            entry_d[0].valid = 1'b1;
            entry_d[0].we    = sb.issue_we_i;
            entry_d[0].waddr = SB_MAX_ADDR_W'(sb.issue_waddr_i);
        end else if (sb.adv_i[0]) begin
            entry_d[0] = '0;
        end
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            if (sb.kill_i[k]) begin
                entry_d[k] = '0;
            end else if (sb.adv_i[k-1]) begin
                entry_d[k] = entry_q[k-1];
            end else if (sb.adv_i[k]) begin
                entry_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    always_comb begin
        incoming    = '0;
        held        = '0;
        incoming[0] = sb.issue_valid_i;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            incoming[k] = sb.adv_i[k-1] & entry_q[k-1].valid;
        end
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            held[k] = entry_q[k].valid & ~sb.adv_i[k] & ~sb.kill_i[k];
        end
    end

    // A valid entry must never be overwritten by one arriving while it is still held.
    assert property (@(posedge clk) disable iff (!rst_n) (incoming & held) == '0);

    for (genvar p = 0; p < REGFILE_NUM_READ_PORTS; p++) begin : g_port
        cv32e41s_sb_match #(
            .PIPE_DEPTH (PIPE_DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .SEL_W      (SB_SEL_W)
        ) u_match (
            .entries    (entry_q),
            .result_rdy (sb.result_rdy_i),
            .re         (sb.rf_re_i[p]),
            .raddr      (sb.rf_raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .sel        (sb.fwd_sel_o[p*SB_SEL_W +: SB_SEL_W]),
            .hazard     (hazard[p])
        );
    end

    assign stall    = |hazard;
    assign sb.stall_o = stall;

`ifdef CV32E41S_SB_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (stall_cnt_clr_i) begin
            cnt_q <= '0;
        end else if (stall && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign stall_cnt_o = cnt_q;
`else
    logic unused_stall_cnt_clr;
    assign unused_stall_cnt_clr = stall_cnt_clr_i;
    assign stall_cnt_o          = '0;
`endif

endmodule

// File: tb/tb_cv32e41s_ctrl_scoreboard.sv
// Self-checking bench: a 2-port/2-stage scoreboard and a 3-port/4-stage one with a
// 3-bit counter, directed scenarios then random traffic against a behavioural model.
module tb_cv32e41s_ctrl_scoreboard;

    localparam int AP = 2, AD = 2, AS = 2, ACW = 16;
    localparam int BP = 3, BD = 4, BS = 3, BCW = 3;
    localparam int AW = 5;
`ifdef CV32E41S_SB_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           clrA, clrB;
    logic [ACW-1:0] cntA;
    logic [BCW-1:0] cntB;

    always #5 clk = ~clk;

    cv32e41s_ctrl_scoreboard_if #(.REGFILE_NUM_READ_PORTS(AP), .PIPE_DEPTH(AD), .ADDR_WIDTH(AW)) ifA ();
    cv32e41s_ctrl_scoreboard_if #(.REGFILE_NUM_READ_PORTS(BP), .PIPE_DEPTH(BD), .ADDR_WIDTH(AW)) ifB ();

    cv32e41s_ctrl_scoreboard #(
        .REGFILE_NUM_READ_PORTS(AP), .PIPE_DEPTH(AD), .ADDR_WIDTH(AW), .CNT_WIDTH(ACW)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .sb(ifA), .stall_cnt_clr_i(clrA), .stall_cnt_o(cntA)
    );

    cv32e41s_ctrl_scoreboard #(
        .REGFILE_NUM_READ_PORTS(BP), .PIPE_DEPTH(BD), .ADDR_WIDTH(AW), .CNT_WIDTH(BCW)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .sb(ifB), .stall_cnt_clr_i(clrB), .stall_cnt_o(cntB)
    );

    int total = 0;
    int bad   = 0;

    logic       inIssue[2], inWe[2], inClr[2];
    logic [4:0] inWaddr[2];
    logic [5:0] inAdv[2], inKill[2], inRdy[2];
    logic [3:0] inRe[2];
    logic [4:0] inRaddr[2][4];

    logic       mValid[2][6], mWe[2][6];
    logic [4:0] mWaddr[2][6];
    int         mCnt[2];

    function automatic int depthOf(int d);  return (d == 0) ? AD : BD; endfunction
    function automatic int portsOf(int d);  return (d == 0) ? AP : BP; endfunction
    function automatic int cntMaxOf(int d); return (d == 0) ? (1 << ACW) - 1 : (1 << BCW) - 1; endfunction

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            inIssue[d] = 1'b0; inWe[d] = 1'b0; inWaddr[d] = '0; inClr[d] = 1'b0;
            inAdv[d] = '0; inKill[d] = '0; inRdy[d] = '0; inRe[d] = '0;
            for (int p = 0; p < 4; p++) inRaddr[d][p] = '0;
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            mCnt[d] = 0;
            for (int k = 0; k < 6; k++) begin
                mValid[d][k] = 1'b0; mWe[d][k] = 1'b0; mWaddr[d][k] = '0;
            end
        end
    endtask

    task automatic applyStimulus();
        ifA.issue_valid_i = inIssue[0];
        ifA.issue_we_i    = inWe[0];
        ifA.issue_waddr_i = inWaddr[0];
        ifA.adv_i         = inAdv[0][AD-1:0];
        ifA.kill_i        = inKill[0][AD-1:0];
        ifA.result_rdy_i  = inRdy[0][AD-1:0];
        ifA.rf_re_i       = inRe[0][AP-1:0];
        ifA.rf_raddr_i    = {inRaddr[0][1], inRaddr[0][0]};
        clrA              = inClr[0];
        ifB.issue_valid_i = inIssue[1];
        ifB.issue_we_i    = inWe[1];
        ifB.issue_waddr_i = inWaddr[1];
        ifB.adv_i         = inAdv[1][BD-1:0];
        ifB.kill_i        = inKill[1][BD-1:0];
        ifB.result_rdy_i  = inRdy[1][BD-1:0];
        ifB.rf_re_i       = inRe[1][BP-1:0];
        ifB.rf_raddr_i    = {inRaddr[1][2], inRaddr[1][1], inRaddr[1][0]};
        clrB              = inClr[1];
    endtask

    // Youngest (lowest stage) matching writer decides forwarding or stall.
    function automatic void modelLookup(input int d, input int p, output int sel, output bit haz);
        sel = 0;
        haz = 1'b0;
        if (!inRe[d][p] || inRaddr[d][p] == 5'd0) return;
        for (int k = 0; k < depthOf(d); k++) begin
            if (mValid[d][k] && mWe[d][k] && mWaddr[d][k] == inRaddr[d][p]) begin
                if (inRdy[d][k]) sel = k + 1;
                else             haz = 1'b1;
                return;
            end
        end
    endfunction

    function automatic void modelUpdate(input int d);
        logic       oV[6], oWe[6];
        logic [4:0] oWa[6];
        int         s;
        bit         h;
        bit         anyHaz = 1'b0;
        for (int p = 0; p < portsOf(d); p++) begin
            modelLookup(d, p, s, h);
            anyHaz |= h;
        end
        if (inClr[d])                               mCnt[d] = 0;
        else if (anyHaz && mCnt[d] < cntMaxOf(d))   mCnt[d] = mCnt[d] + 1;
        for (int k = 0; k < 6; k++) begin
            oV[k] = mValid[d][k]; oWe[k] = mWe[d][k]; oWa[k] = mWaddr[d][k];
        end
        for (int k = 0; k < depthOf(d); k++) begin
            if (inKill[d][k]) begin
                mValid[d][k] = 1'b0;
            end else if (k == 0 && inIssue[d]) begin
                mValid[d][0] = 1'b1; mWe[d][0] = inWe[d]; mWaddr[d][0] = inWaddr[d];
            end else if (k > 0 && inAdv[d][k-1]) begin
                mValid[d][k] = oV[k-1]; mWe[d][k] = oWe[k-1]; mWaddr[d][k] = oWa[k-1];
            end else if (inAdv[d][k]) begin
                mValid[d][k] = 1'b0;
            end
        end
    endfunction

    // Force a stage to advance whenever something would otherwise land on it while occupied.
    function automatic void legalize(input int d);
        for (int k = 0; k < depthOf(d); k++) begin
            if (((k == 0) ? inIssue[d] : inAdv[d][k-1]) && mValid[d][k] && !inAdv[d][k])
                inAdv[d][k] = 1'b1;
        end
    endfunction

    function automatic logic [31:0] obsSel(int d, int p);
        return (d == 0) ? 32'(ifA.fwd_sel_o[p*AS +: AS]) : 32'(ifB.fwd_sel_o[p*BS +: BS]);
    endfunction
    function automatic logic [31:0] obsStall(int d);
        return (d == 0) ? 32'(ifA.stall_o) : 32'(ifB.stall_o);
    endfunction
    function automatic logic [31:0] obsCnt(int d);
        return (d == 0) ? 32'(cntA) : 32'(cntB);
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        int s;
        bit h;
        for (int d = 0; d < 2; d++) begin
            bit anyHaz = 1'b0;
            for (int p = 0; p < portsOf(d); p++) begin
                modelLookup(d, p, s, h);
                anyHaz |= h;
                checkVal($sformatf("%s.sel%0d", d == 0 ? "A" : "B", p), obsSel(d, p), 32'(s));
            end
            checkVal($sformatf("%s.stall", d == 0 ? "A" : "B"), obsStall(d), 32'(anyHaz));
            checkVal($sformatf("%s.cnt", d == 0 ? "A" : "B"), obsCnt(d), CNT_EN ? 32'(mCnt[d]) : 32'd0);
        end
    endtask

    task automatic settle();
        applyStimulus();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < 2; d++) modelUpdate(d);
        #1;
    endtask

    initial begin
        idle();
        modelReset();
        applyStimulus();
        @(negedge clk);
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle pipe: reads of x3/x7 go to the regfile.
        inRe[0] = 4'b0011; inRaddr[0][0] = 5'd3; inRaddr[0][1] = 5'd7;
        settle();
        checkVal("idle.sel0", obsSel(0, 0), 32'd0);
        checkVal("idle.sel1", obsSel(0, 1), 32'd0);
        checkVal("idle.stall", obsStall(0), 32'd0);
        checkVal("idle.cnt", obsCnt(0), 32'd0);
        tick();

        // x5 forwarded from EX, then from WB.
        idle(); inIssue[0] = 1'b1; inWe[0] = 1'b1; inWaddr[0] = 5'd5;
        settle(); tick();
        idle(); inRe[0] = 4'b0010; inRaddr[0][1] = 5'd5; inRdy[0] = 6'b01; inAdv[0] = 6'b01;
        settle();
        checkVal("x5.ex.sel1", obsSel(0, 1), 32'd1);
        checkVal("x5.ex.stall", obsStall(0), 32'd0);
        tick();
        idle(); inRe[0] = 4'b0010; inRaddr[0][1] = 5'd5; inRdy[0] = 6'b10; inAdv[0] = 6'b10;
        settle();
        checkVal("x5.wb.sel1", obsSel(0, 1), 32'd2);
        tick();

        // Load-use on x9: three stall cycles in WB, then forwarded.
        idle(); inIssue[0] = 1'b1; inWe[0] = 1'b1; inWaddr[0] = 5'd9;
        settle(); tick();
        idle(); inAdv[0] = 6'b01;
        settle(); tick();
        for (int i = 0; i < 3; i++) begin
            idle(); inRe[0] = 4'b0001; inRaddr[0][0] = 5'd9;
            settle();
            checkVal("x9.stall", obsStall(0), 32'd1);
            tick();
        end
        idle(); inRe[0] = 4'b0001; inRaddr[0][0] = 5'd9; inRdy[0] = 6'b10; inAdv[0] = 6'b10;
        settle();
        checkVal("x9.sel0", obsSel(0, 0), 32'd2);
        checkVal("x9.nostall", obsStall(0), 32'd0);
        checkVal("x9.cnt", obsCnt(0), CNT_EN ? 32'd3 : 32'd0);
        tick();

        // Two x4 writers: youngest wins, then killing it exposes the older one.
        idle(); inIssue[0] = 1'b1; inWe[0] = 1'b1; inWaddr[0] = 5'd4;
        settle(); tick();
        idle(); inIssue[0] = 1'b1; inWe[0] = 1'b1; inWaddr[0] = 5'd4; inAdv[0] = 6'b01;
        settle(); tick();
        idle(); inRe[0] = 4'b0001; inRaddr[0][0] = 5'd4; inRdy[0] = 6'b11; inKill[0] = 6'b01;
        settle();
        checkVal("x4.young", obsSel(0, 0), 32'd1);
        tick();
        idle(); inRe[0] = 4'b0001; inRaddr[0][0] = 5'd4; inRdy[0] = 6'b11;
        settle();
        checkVal("x4.old", obsSel(0, 0), 32'd2);
        tick();
        idle(); inKill[0] = 6'b11;
        settle(); tick();

        // x0 writes never forward or stall.
        idle(); inIssue[0] = 1'b1; inWe[0] = 1'b1; inWaddr[0] = 5'd0;
        settle(); tick();
        idle(); inRe[0] = 4'b0011; inRaddr[0][0] = 5'd0; inRaddr[0][1] = 5'd0;
        settle();
        checkVal("x0.sel0", obsSel(0, 0), 32'd0);
        checkVal("x0.stall", obsStall(0), 32'd0);
        tick();
        idle(); inKill[0] = 6'b11;
        settle(); tick();

        // Deep instance: saturate the 3-bit counter, then clear while still stalling.
        idle(); inIssue[1] = 1'b1; inWe[1] = 1'b1; inWaddr[1] = 5'd6;
        settle(); tick();
        for (int i = 0; i < 9; i++) begin
            idle(); inRe[1] = 4'b0100; inRaddr[1][2] = 5'd6;
            settle();
            checkVal("B.sat.stall", obsStall(1), 32'd1);
            tick();
        end
        idle(); inRe[1] = 4'b0100; inRaddr[1][2] = 5'd6; inClr[1] = 1'b1;
        settle();
        checkVal("B.sat.cnt", obsCnt(1), CNT_EN ? 32'd7 : 32'd0);
        tick();
        idle(); inRe[1] = 4'b0100; inRaddr[1][2] = 5'd6;
        settle();
        checkVal("B.clr.cnt", obsCnt(1), 32'd0);
        tick();
        idle(); inKill[1] = 6'b1111;
        settle(); tick();

        // Random legal traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 2; d++) begin
                inIssue[d] = 1'($urandom_range(0, 1));
                inWe[d]    = 1'($urandom_range(0, 3) != 0);
                inWaddr[d] = 5'($urandom_range(0, 7));
                inAdv[d]   = 6'($urandom);
                inKill[d]  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
                inRdy[d]   = 6'($urandom);
                inRe[d]    = 4'($urandom);
                inClr[d]   = 1'($urandom_range(0, 15) == 0);
                for (int p = 0; p < 4; p++) inRaddr[d][p] = 5'($urandom_range(0, 7));
                legalize(d);
            end
            settle();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cv32e41s_ctrl_scoreboard.md
Name: cv32e41s_ctrl_scoreboard

Overview:
- Parametrised successor to the fixed two-stage hazard/bypass control.
- Tracks in-flight register writes through a configurable number of post-ID pipeline stages.
- For any number of register-file read ports it produces per-port forwarding selects and a single ID-stage stall.
- Sits beside the controller FSM; driven by the stage handshakes and flush signals.

Parameters:
- REGFILE_NUM_READ_PORTS, 2: number of ID read ports checked, 1..4.
- PIPE_DEPTH, 2: tracked stages after ID (stage 0 = EX, stage PIPE_DEPTH-1 = WB), 1..6.
- ADDR_WIDTH, 5: register address width.
- CNT_WIDTH, 16: width of the optional stall counter.

Ports:
- clk  in  1  gated core clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid_i  in  1  instruction leaves ID this cycle (id_valid & ex_ready)
- issue_we_i  in  1  issued instruction writes the register file
- issue_waddr_i  in  ADDR_WIDTH  destination register of the issued instruction
- adv_i  in  PIPE_DEPTH  bit k: stage k hands to k+1; last bit = retire
- kill_i  in  PIPE_DEPTH  bit k: flush stage k this cycle
- result_rdy_i  in  PIPE_DEPTH  bit k: stage k result is forwardable this cycle
- rf_re_i  in  REGFILE_NUM_READ_PORTS  read enable per port
- rf_raddr_i  in  REGFILE_NUM_READ_PORTS*ADDR_WIDTH  packed read addresses
- stall_cnt_clr_i  in  1  clear the stall counter
- fwd_sel_o  out  REGFILE_NUM_READ_PORTS*SB_SEL_W  per port: 0 = regfile, k+1 = stage k
- stall_o  out  1  ID must stall (load-use or late-result hazard)
- stall_cnt_o  out  CNT_WIDTH  count of stall cycles

Behaviour:
- State: one entry per stage {valid, we, waddr}. Reset: all entries invalid, counter 0. Consequently fwd_sel_o = 0, stall_o = 0 and stall_cnt_o = 0 out of reset.
- Stage 0 next value:
  - kill_i[0] → invalid;
  - else issue_valid_i → {1, issue_we_i, issue_waddr_i};
  - else adv_i[0] → invalid;
  - else hold.
- Stage k>0 next value:
  - kill_i[k] → invalid;
  - else adv_i[k-1] → copy of stage k-1 (an invalid source copies as invalid);
  - else adv_i[k] → invalid;
  - else hold.
- Kill has priority over any incoming transfer into the same stage. Killing stage k does not affect stage k+1 receiving from k in the same cycle unless kill_i[k+1] is also set.
- Legal-use rule, checked by assertion: an incoming transfer or issue into stage k requires stage k to be empty or adv_i[k] to be set.
- Lookup, per port p, combinational from registered state and result_rdy_i:
  - If rf_re_i[p] is low or the address is 0: no hazard, sel = 0.
  - Otherwise find the smallest k with valid & we & waddr match (youngest writer wins).
  - No match: sel = 0.
  - Match with result_rdy_i[k] set: sel = k+1.
  - Match with result_rdy_i[k] clear: sel = 0 and a hazard is flagged.
- stall_o = OR of hazards over all ports.
- Latency: zero-cycle lookup. A newly issued entry is visible to the next ID instruction in the cycle after issue.
- Retire-and-read in the same cycle: the last stage still holds the entry, so forwarding covers write-through.
- The same destination in several stages is legal; only the youngest is used.
- The scoreboard never stalls itself; stall_o is consumed by the controller FSM.

Optional Feature:
- CV32E41S_SB_STALL_CNT_EN defined:
  - stall_cnt_o increments each cycle stall_o = 1 and saturates at all-ones.
  - stall_cnt_clr_i has priority over increment and clears to 0 next cycle.
- Macro undefined: counter not built, stall_cnt_o tied to 0, stall_cnt_clr_i ignored.

Decomposition:
- cv32e41s_pkg gains:
  - sb_entry_t {valid, we, waddr};
  - function sb_sel_w(PIPE_DEPTH) = $clog2(PIPE_DEPTH+1), used for SB_SEL_W;
  - localparam SB_SEL_RF = 0.
- Sub-module cv32e41s_sb_match: one combinational priority lookup per read port, instantiated REGFILE_NUM_READ_PORTS times in a generate loop. Outputs sel and hazard for its port.

Test Plan:
- Reset, then rf_re=2'b11 with addresses 3 and 7 on an idle pipe → fwd_sel = 0/0, stall_o = 0, stall_cnt_o = 0.
- Issue x5 with result_rdy[0]=1; next cycle read x5 on port 1 → sel port1 = 1, stall_o = 0. After adv_i[0] with result_rdy[1]=1 → sel = 2.
- Load to x9 with result_rdy[1]=0 in WB and a read of x9 → stall_o = 1, held until result_rdy[1]=1. Then sel = 2 with stall_o = 0; counter equals the number of stall cycles.
- x4 in stage 1 and a newer x4 in stage 0, both ready → sel = 1 (youngest). kill_i[0] → sel = 2 next cycle.
- Write to x0 in flight and a read of x0 → sel = 0, no stall.
- PIPE_DEPTH=4, 3 ports, with the counter preset near saturation: a stall at all-ones holds the value. stall_cnt_clr_i together with stall → 0 next cycle.
